// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, FSM state type and direction bit positions
// for the PS/2 keyboard sequencer.
package keyboard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } kbd_state_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // Bit positions inside the {up,down,left,right} direction vectors
    localparam logic [1:0] DIR_UP    = 2'd3;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd0;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

endpackage

// File: rtl/keyboard_keymap.sv
// Combinational lookup of an (extended flag, scan code) pair to the game
// control it drives: owning player, direction bit or bomb.
module keyboard_keymap
    import keyboard_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       player,
    output logic [1:0] dir_idx,
    output logic       is_bomb,
    output logic       hit
);

    always_comb begin
        player  = PLAYER1;
        dir_idx = DIR_RIGHT;
        is_bomb = 1'b0;
        hit     = 1'b1;
        case ({ext, code})
            {1'b0, SC_W}:     dir_idx = DIR_UP;
            {1'b0, SC_S}:     dir_idx = DIR_DOWN;
            {1'b0, SC_A}:     dir_idx = DIR_LEFT;
            {1'b0, SC_D}:     dir_idx = DIR_RIGHT;
            {1'b0, SC_SPACE}: is_bomb = 1'b1;
            {1'b1, SC_UP}:    begin player = PLAYER2; dir_idx = DIR_UP;    end
            {1'b1, SC_DOWN}:  begin player = PLAYER2; dir_idx = DIR_DOWN;  end
            {1'b1, SC_LEFT}:  begin player = PLAYER2; dir_idx = DIR_LEFT;  end
            {1'b1, SC_RIGHT}: begin player = PLAYER2; dir_idx = DIR_RIGHT; end
            {1'b0, SC_ENTER}: begin player = PLAYER2; is_bomb = 1'b1;      end
            default:          hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/keyboard_ctrl.sv
// PS/2 Set 2 scan-code sequencer: prefix tracking, held-key state for two
// players, bomb pulses, generic key events and prefix timeout resync.
module keyboard_ctrl
    import keyboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] p1_dir,
    output logic       p1_bomb,
    output logic [3:0] p2_dir,
    output logic       p2_bomb,
    output logic       key_evt,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       sync_lost
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SW = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SKIP_INIT = SW'(PAUSE_SKIP);

    kbd_state_t    state, state_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic [SW-1:0] skip_cnt, skip_cnt_d;
    logic          do_make, do_break, evt_ext, timeout, clr_keys;
    logic          p1_bomb_held, p2_bomb_held;

    logic          map_player, map_bomb, map_hit;
    logic [1:0]    map_dir;

    keyboard_keymap u_keymap (
        .ext     (evt_ext),
        .code    (rx_data),
        .player  (map_player),
        .dir_idx (map_dir),
        .is_bomb (map_bomb),
        .hit     (map_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            to_cnt   <= '0;
            skip_cnt <= '0;
        end else begin
            state    <= state_d;
            to_cnt   <= to_cnt_d;
            skip_cnt <= skip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        to_cnt_d   = to_cnt;
        skip_cnt_d = skip_cnt;
        do_make    = 1'b0;
        do_break   = 1'b0;
        evt_ext    = 1'b0;
        timeout    = 1'b0;
        clr_keys   = 1'b0;

        // A byte arriving on the expiry cycle wins, so timeout needs !rx_valid
        if (rx_valid || state == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt == TO_LAST) begin
            timeout = 1'b1;
        end else begin
            to_cnt_d = to_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        SC_E0: state_d = EXT;
                        SC_F0: state_d = BRK;
                        SC_E1: begin
                            if (PAUSE_SKIP != 0) begin
                                state_d    = SKIP;
                                skip_cnt_d = SKIP_INIT;
                            end
                        end
                        SC_AA: clr_keys = 1'b1;
                        SC_ACK, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1: ;
                        default: do_make = 1'b1;
                    endcase
                end
            end
            EXT: begin
                evt_ext = 1'b1;
                if (rx_valid) begin
                    case (rx_data)
                        SC_F0: state_d = EXT_BRK;
                        SC_E0: ;
                        default: begin
                            do_make = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            BRK: begin
                if (rx_valid) begin
                    do_break = 1'b1;
                    state_d  = IDLE;
                end
            end
            EXT_BRK: begin
                evt_ext = 1'b1;
                if (rx_valid) begin
                    do_break = 1'b1;
                    state_d  = IDLE;
                end
            end
            SKIP: begin
                if (rx_valid) begin
                    if (skip_cnt <= SW'(1)) begin
                        skip_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        skip_cnt_d = skip_cnt - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d    = IDLE;
            skip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_dir       <= '0;
            p2_dir       <= '0;
            p1_bomb      <= 1'b0;
            p2_bomb      <= 1'b0;
            p1_bomb_held <= 1'b0;
            p2_bomb_held <= 1'b0;
            key_evt      <= 1'b0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            key_break    <= 1'b0;
            sync_lost    <= 1'b0;
        end else begin
            key_evt   <= do_make | do_break;
            sync_lost <= timeout;
            p1_bomb   <= 1'b0;
            p2_bomb   <= 1'b0;

            if (do_make || do_break) begin
                key_code  <= rx_data;
                key_ext   <= evt_ext;
                key_break <= do_break;
            end

            if (clr_keys) begin
                p1_dir       <= '0;
                p2_dir       <= '0;
                p1_bomb_held <= 1'b0;
                p2_bomb_held <= 1'b0;
            end

            if (map_hit && (do_make || do_break)) begin
                if (map_bomb) begin
                    // Pulse only on the first make; typematic repeats see held set
                    if (map_player == PLAYER1) begin
                        p1_bomb      <= do_make & ~p1_bomb_held;
                        p1_bomb_held <= do_make;
                    end else begin
                        p2_bomb      <= do_make & ~p2_bomb_held;
                        p2_bomb_held <= do_make;
                    end
                end else if (map_player == PLAYER1) begin
                    p1_dir[map_dir] <= do_make;
                end else begin
                    p2_dir[map_dir] <= do_make;
                end
            end
        end
    end

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Bench for keyboard_ctrl: directed scenarios then a random byte stream,
// compared every cycle against a key-table reference model.
module tb_keyboard_ctrl;

    localparam int unsigned T  = 16;
    localparam int unsigned PS = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] p1_dir, p2_dir;
    logic       p1_bomb, p2_bomb, key_evt, key_ext, key_break, sync_lost;
    logic [7:0] key_code;

    always #5 clk = ~clk;

    keyboard_ctrl #(.TIMEOUT_CYCLES(T), .PAUSE_SKIP(PS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .p1_dir    (p1_dir),
        .p1_bomb   (p1_bomb),
        .p2_dir    (p2_dir),
        .p2_bomb   (p2_bomb),
        .key_evt   (key_evt),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .sync_lost (sync_lost)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: every (ext,code) key held or not, plus pending prefixes
    bit         held [0:511];
    bit         pend_ext, pend_brk;
    int         skip_left, waited;
    logic       e_evt, e_ext, e_brk, e_p1b, e_p2b, e_sync;
    logic [7:0] e_code;

    task automatic model_reset();
        foreach (held[i]) held[i] = 1'b0;
        pend_ext = 0; pend_brk = 0; skip_left = 0; waited = 0;
        e_evt = 0; e_ext = 0; e_brk = 0; e_p1b = 0; e_p2b = 0; e_sync = 0;
        e_code = 8'h00;
    endtask

    task automatic model_event(bit brk, bit x, logic [7:0] c);
        e_evt = 1; e_code = c; e_ext = x; e_brk = brk;
        if (!brk) begin
            if (!x && c == 8'h29 && !held[{x, c}]) e_p1b = 1;
            if (!x && c == 8'h5A && !held[{x, c}]) e_p2b = 1;
        end
        held[{x, c}] = !brk;
    endtask

    task automatic model_step(bit v, logic [7:0] d);
        e_evt = 0; e_p1b = 0; e_p2b = 0; e_sync = 0;
        if (v) begin
            waited = 0;
            if (skip_left > 0) begin
                skip_left--;
            end else if (!pend_ext && !pend_brk) begin
                case (d)
                    8'hE0: pend_ext = 1;
                    8'hF0: pend_brk = 1;
                    8'hE1: skip_left = PS;
                    8'hAA: foreach (held[i]) held[i] = 1'b0;
                    8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: model_event(0, 0, d);
                endcase
            end else if (pend_ext && !pend_brk) begin
                if (d == 8'hF0) pend_brk = 1;
                else if (d != 8'hE0) begin
                    model_event(0, 1, d);
                    pend_ext = 0;
                end
            end else begin
                model_event(1, pend_ext, d);
                pend_ext = 0; pend_brk = 0;
            end
        end else if (pend_ext || pend_brk || skip_left > 0) begin
            waited++;
            if (waited == T) begin
                pend_ext = 0; pend_brk = 0; skip_left = 0; waited = 0;
                e_sync = 1;
            end
        end
    endtask

    function automatic logic [3:0] dirs(bit x, logic [7:0] u, logic [7:0] dn,
                                        logic [7:0] l, logic [7:0] r);
        return {held[{x, u}], held[{x, dn}], held[{x, l}], held[{x, r}]};
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("p1_dir", {4'h0, p1_dir}, {4'h0, dirs(0, 8'h1D, 8'h1B, 8'h1C, 8'h23)});
        chk("p2_dir", {4'h0, p2_dir}, {4'h0, dirs(1, 8'h75, 8'h72, 8'h6B, 8'h74)});
        chk("p1_bomb", {7'h0, p1_bomb}, {7'h0, e_p1b});
        chk("p2_bomb", {7'h0, p2_bomb}, {7'h0, e_p2b});
        chk("key_evt", {7'h0, key_evt}, {7'h0, e_evt});
        chk("key_code", key_code, e_code);
        chk("key_ext", {7'h0, key_ext}, {7'h0, e_ext});
        chk("key_break", {7'h0, key_break}, {7'h0, e_brk});
        chk("sync_lost", {7'h0, sync_lost}, {7'h0, e_sync});
    endtask

    task automatic tick(bit v, logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        check_all();
        rx_valid = 1'b0;
    endtask

    task automatic send(logic [7:0] b[$]);
        foreach (b[i]) tick(1, b[i]);
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 8'h00);
    endtask

    logic [7:0] pool [20];

    initial begin
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h14, 8'h77};
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        check_all();
        reset_n = 1'b1;

        // Held key with typematic repeats, then release
        send('{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D});
        idle(2);
        // Bomb: first make, repeat, break, make again
        send('{8'h29});
        idle(1);
        send('{8'h29, 8'hF0, 8'h29, 8'h29});
        idle(1);
        // Extended arrow versus bare keypad code
        send('{8'hE0, 8'h75});
        idle(1);
        send('{8'hE0, 8'hF0, 8'h75, 8'h75, 8'hF0, 8'h75});
        // Keypad Enter versus main Enter
        send('{8'hE0, 8'h5A, 8'h5A, 8'hF0, 8'h5A, 8'hE0, 8'hF0, 8'h5A});
        // Timeout after F0, then fresh make
        send('{8'hF0});
        idle(T);
        send('{8'h1C});
        // Byte on the expiry cycle is decoded, no sync_lost
        send('{8'hF0});
        idle(T - 1);
        send('{8'h1C});
        // Pause sequence swallowed, then D
        send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h23});
        // Keyboard self-test clears held directions
        send('{8'hE0, 8'h72, 8'h1B, 8'hAA});
        idle(1);
        // Timeout while skipping Pause bytes
        send('{8'hE1, 8'h14});
        idle(T);
        send('{8'h1D});
        // Reset in the middle of an E0 prefix
        send('{8'hE0});
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        check_all();
        reset_n = 1'b1;
        send('{8'h75});

        // Random stream with bursts and long gaps
        repeat (3000) begin
            if ($urandom_range(0, 9) < 3)
                idle($urandom_range(0, ($urandom_range(0, 7) == 0) ? T + 4 : 3));
            if ($urandom_range(0, 15) == 0)
                tick(1, 8'($urandom));
            else
                tick(1, pool[$urandom_range(0, 19)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
